// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multicycle signed multiply / divide coprocessor for the MIPS
//            datapath. mult uses radix-2 Booth and produces a 2*WIDTH product
//            on hi/lo. div uses restoring division and produces the remainder
//            on hi and the quotient on lo. Divide by zero raises div_zero and
//            leaves hi/lo unchanged.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-high reset
//            start    - request strobe, sampled in IDLE only
//            op       - 0 = mult, 1 = div (sampled with start)
//            a, b     - multiplicand/dividend, multiplier/divisor
//            hi, lo   - result halves (registered, held between operations)
//            busy     - operation in progress
//            done     - one-cycle completion pulse
//            div_zero - one-cycle pulse with done on divide by zero
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               op_q, dz_q, qneg_q, rneg_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     opnd_q;
  // mult: {acc[WIDTH:0], multiplier[WIDTH-1:0], q-1}
  // div : {2'b0, remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
  logic [2*WIDTH+1:0] work_q, work_d;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               b_zero;
  logic [WIDTH:0]     acc_n, diff;
  logic [2*WIDTH-1:0] shl;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign a_abs  = a[WIDTH-1] ? -a : a;
  assign b_abs  = b[WIDTH-1] ? -b : b;
  assign b_zero = (b == '0);

  // One iteration of the selected algorithm.
  // The Booth accumulator carries one guard bit so that subtracting the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    acc_n  = work_q[2*WIDTH+1:WIDTH+1];
    diff   = '0;
    shl    = {work_q[2*WIDTH-1:0], 1'b0};
    work_d = work_q;
    if (!op_q) begin
      case (work_q[1:0])
        2'b01:   acc_n = work_q[2*WIDTH+1:WIDTH+1] + opnd_q;
        2'b10:   acc_n = work_q[2*WIDTH+1:WIDTH+1] - opnd_q;
        default: acc_n = work_q[2*WIDTH+1:WIDTH+1];
      endcase
      work_d = {acc_n[WIDTH], acc_n, work_q[WIDTH:1]};
    end else begin
      diff = {1'b0, shl[2*WIDTH-1:WIDTH]} - opnd_q;
      if (!diff[WIDTH]) begin
        work_d = {2'b00, diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
      end else begin
        work_d = {2'b00, shl};
      end
    end
  end

  // Final results; division applies the signs to the magnitudes.
  always_comb begin
    if (!op_q) begin
      res_hi = work_q[2*WIDTH:WIDTH+1];
      res_lo = work_q[WIDTH:1];
    end else begin
      res_hi = rneg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
      res_lo = qneg_q ? -work_q[WIDTH-1:0]       : work_q[WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. RUN exits once the counter reaches LAST: after 32
  // iterations normally, or one cycle after start on divide by zero (the
  // counter is preloaded to LAST so no iteration runs).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (cnt_q == LAST) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode only flops, so there is no input-to-output path.
  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_FINISH);
    div_zero = (state_q == S_FINISH) && dz_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 1'b0;
      dz_q   <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      work_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dz_q   <= op & b_zero;
            cnt_q  <= (op & b_zero) ? LAST : '0;
            qneg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            rneg_q <= a[WIDTH-1];
            if (op) begin
              opnd_q <= {1'b0, b_abs};
              work_q <= {{(WIDTH+2){1'b0}}, a_abs};
            end else begin
              opnd_q <= {a[WIDTH-1], a};
              work_q <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            end
          end
        end
        S_RUN: begin
          if (cnt_q != LAST) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CW'(1);
          end else if (!dz_q) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed and randomised stimulus for mult_div_unit. Expected
//            results are queued when an operation is started and compared
//            when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] cyc = '0;
  int          busy_run = 0;
  int          last_run = 0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      busy_run  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (div_zero && !done) check("dz_without_done", 64'(div_zero), 64'(0));
      if (done) begin
        exp_t e;
        check("done_single_cycle", 64'(done_prev), 64'(0));
        last_run = busy_run;
        busy_run = 0;
        check("done_expected", 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("div_zero", 64'(div_zero), 64'(e.dz));
          check("latency", 64'(cyc), 64'(e.due));
        end
      end
      done_prev = done;
    end
  end

  task automatic go(input logic o, input logic [31:0] ia, input logic [31:0] ib,
                    input logic [31:0] eh, input logic [31:0] el, input logic edz,
                    input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    e.hi = eh; e.lo = el; e.dz = edz; e.due = cyc + 32'(lat);
    sb.push_back(e);
  endtask

  task automatic wait_done(input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // 7 * -3
    go(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    wait_done(40);
    check("mult_busy_cycles", 64'(last_run), 64'(33));

    // most negative squared
    go(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
    wait_done(40);

    // -7 / 2
    go(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    wait_done(40);

    // 0x451 / 0x20 leaves hi=0x11, lo=0x22, then divide by zero keeps them
    go(1'b1, 32'h0000_0451, 32'h0000_0020, 32'h11, 32'h22, 1'b0, 33);
    wait_done(40);
    go(1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1);
    wait_done(5);
    check("dz_busy_cycles", 64'(last_run), 64'(1));
    @(negedge clk);
    #1;
    check("dz_hi_held", 64'(hi), 64'(32'h11));
    check("dz_lo_held", 64'(lo), 64'(32'h22));
    check("dz_pulse_end", 64'(div_zero), 64'(0));

    // overflow case
    go(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    wait_done(40);

    // randomised operations against a behavioural model
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        ro;
      longint      p;
      int          q, r;
      ra = $urandom;
      rb = $urandom;
      ro = i[0];
      if (i >= 4) rb = rb >> 20;
      if (ro && rb == 32'd0) rb = 32'd1;
      if (ro && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      if (!ro) begin
        p = longint'(signed'(ra)) * longint'(signed'(rb));
        go(1'b0, ra, rb, p[63:32], p[31:0], 1'b0, 33);
      end else begin
        q = signed'(ra) / signed'(rb);
        r = signed'(ra) % signed'(rb);
        go(1'b1, ra, rb, r, q, 1'b0, 33);
      end
      wait_done(40);
    end

    // start while busy is ignored
    go(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40);
    // start during the FINISH cycle is ignored too
    start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("ignored_busy", 64'(busy), 64'(0));
    check("ignored_hi", 64'(hi), 64'(0));
    check("ignored_lo", 64'(lo), 64'(12));

    // reset mid-operation
    go(1'b0, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 33);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    go(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
    wait_done(40);
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
